// File: rtl/chip8_audio_pkg.sv
// Shared definitions for the CHIP-8 beeper: state encoding, level limit, counter width.
package chip8_audio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } beeper_state_t;

    localparam logic [3:0] LEVEL_MAX = 4'd15;
    localparam int         CNT_W     = 24;

endpackage

// File: rtl/beeper_pwm.sv
// 16-step PWM renderer: gates the tone high half with a duty cycle of env_level/16.
module beeper_pwm (
    input  logic       clk,
    input  logic       rst,
    input  logic       tone_phase,
    input  logic [3:0] env_level,
    output logic       audio_out
);

    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt   <= 4'd0;
            audio_out <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + 4'd1;
            audio_out <= tone_phase && (pwm_cnt < env_level);
        end
    end

endmodule

// File: rtl/chip8_beeper.sv
// CHIP-8 sound-timer beeper: square-wave tone with envelope-shaped PWM amplitude.
// Define CHIP8_BEEPER_ENVELOPE_EN for the attack/release ramp; otherwise the level switches 0 <-> 15.
module chip8_beeper
    import chip8_audio_pkg::*;
#(
    parameter int TONE_HALF_PERIOD = 113636,
    parameter int ENV_STEP_CYCLES  = 62500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sound_timer,
    input  logic       mute,
    output logic       audio_out,
    output logic       beep_active,
    output logic [3:0] env_level
);

    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_HALF_PERIOD - 1);

    if (TONE_HALF_PERIOD < 2 || TONE_HALF_PERIOD > (1 << CNT_W) - 1 ||
        ENV_STEP_CYCLES < 1 || ENV_STEP_CYCLES > (1 << CNT_W) - 1) begin : g_param_check
        $error("chip8_beeper: TONE_HALF_PERIOD or ENV_STEP_CYCLES out of range");
    end

    logic             gate;
    logic             gate_q;
    beeper_state_t    state;
    beeper_state_t    next_state;
    logic [3:0]       level_next;
    logic [CNT_W-1:0] tone_cnt;
    logic             tone_phase;

    assign gate = (sound_timer != 8'd0) && !mute;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            env_level   <= 4'd0;
            beep_active <= 1'b0;
        end else begin
            state       <= next_state;
            env_level   <= level_next;
            beep_active <= (next_state != IDLE);
        end
    end

`ifdef CHIP8_BEEPER_ENVELOPE_EN
    localparam logic [CNT_W-1:0] ENV_LAST = CNT_W'(ENV_STEP_CYCLES - 1);

    logic [CNT_W-1:0] env_cnt;
    logic             env_tick;

    assign env_tick = (env_cnt == ENV_LAST);

    // Restarting on every state change makes each new ramp begin a full step later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            env_cnt <= '0;
        end else if (next_state != state || env_tick) begin
            env_cnt <= '0;
        end else begin
            env_cnt <= env_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (gate_q) next_state = ATTACK;
            ATTACK: begin
                if (!gate_q)
                    next_state = RELEASE;
                else if (env_tick && env_level == LEVEL_MAX - 4'd1)
                    next_state = SUSTAIN;
            end
            SUSTAIN: if (!gate_q) next_state = RELEASE;
            RELEASE: begin
                if (gate_q)
                    next_state = ATTACK;
                else if (env_level == 4'd0 || (env_tick && env_level == 4'd1))
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // A gate change freezes the level for that cycle even if a tick coincides.
    always_comb begin
        level_next = env_level;
        case (state)
            IDLE:    level_next = 4'd0;
            ATTACK:  if (gate_q && env_tick && env_level != LEVEL_MAX) level_next = env_level + 4'd1;
            SUSTAIN: level_next = LEVEL_MAX;
            RELEASE: if (!gate_q && env_tick && env_level != 4'd0) level_next = env_level - 4'd1;
            default: level_next = 4'd0;
        endcase
    end
`else
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (gate_q) next_state = SUSTAIN;
            SUSTAIN: if (!gate_q) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        level_next = (next_state == SUSTAIN) ? LEVEL_MAX : 4'd0;
    end
`endif

    // Every beep starts on a high half-cycle; re-attacks from release keep the running phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tone_cnt   <= '0;
            tone_phase <= 1'b0;
        end else if (next_state == IDLE) begin
            tone_cnt   <= '0;
            tone_phase <= 1'b0;
        end else if (state == IDLE) begin
            tone_cnt   <= '0;
            tone_phase <= 1'b1;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt   <= '0;
            tone_phase <= ~tone_phase;
        end else begin
            tone_cnt   <= tone_cnt + 1'b1;
        end
    end

    beeper_pwm u_pwm (
        .clk        (clk),
        .rst        (rst),
        .tone_phase (tone_phase),
        .env_level  (env_level),
        .audio_out  (audio_out)
    );

endmodule

// File: tb/tb_chip8_beeper.sv
// Scoreboard bench for chip8_beeper: per-cycle expectations are queued with each stimulus step.
module tb_chip8_beeper;

    localparam int THP = 4;
    localparam int ESC = 2;
`ifdef CHIP8_BEEPER_ENVELOPE_EN
    localparam int RAMP = 15 * ESC;
`else
    localparam int RAMP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sound_timer = 8'd0;
    logic       mute = 1'b0;
    logic       audio_out;
    logic       beep_active;
    logic [3:0] env_level;

    chip8_beeper #(
        .TONE_HALF_PERIOD (THP),
        .ENV_STEP_CYCLES  (ESC)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .sound_timer (sound_timer),
        .mute        (mute),
        .audio_out   (audio_out),
        .beep_active (beep_active),
        .env_level   (env_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       beep;
        logic [3:0] level;
        logic       audio;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         edge_k = 0;
    int         beep_start = 0;
    logic       prev_phase = 1'b0;
    logic [3:0] prev_level = 4'd0;

    function automatic logic phase_of(input int k);
        return (((k - beep_start) / THP) % 2) == 0;
    endfunction

    function automatic logic [3:0] attack_level(input int n);
        int v;
        if (n < 2) return 4'd0;
        if (RAMP == 0) return 4'd15;
        v = (n - 2) / ESC;
        if (v > 15) v = 15;
        return 4'(v);
    endfunction

    // Audio lags tone phase and level by one register, gated by the free-running PWM count.
    task automatic push_step(input logic beep, input logic [3:0] level, input logic phase);
        exp_t e;
        e.beep  = beep;
        e.level = level;
        e.audio = prev_phase && (4'(edge_k % 16) < prev_level);
        sb.push_back(e);
        prev_phase = phase;
        prev_level = level;
        edge_k++;
    endtask

    task automatic push_attack(input int len);
        beep_start = edge_k + 1;
        for (int n = 1; n <= len; n++) begin
            if (n < 2) push_step(1'b0, 4'd0, 1'b0);
            else       push_step(1'b1, attack_level(n), phase_of(edge_k));
        end
    endtask

    task automatic push_release(input int len);
        for (int n = 1; n <= len; n++) begin
            if (n == 1)             push_step(1'b1, 4'd15, phase_of(edge_k));
            else if (n < 2 + RAMP)  push_step(1'b1, 4'(15 - (n - 2) / ESC), phase_of(edge_k));
            else                    push_step(1'b0, 4'd0, 1'b0);
        end
    endtask

    task automatic push_idle(input int len);
        for (int n = 1; n <= len; n++) push_step(1'b0, 4'd0, 1'b0);
    endtask

    task automatic check_output(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s beep/level/audio observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] timer, input logic mute_in);
        sound_timer = timer;
        mute        = mute_in;
    endtask

    task automatic run_cycles(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL %s[%0d] scoreboard empty observed=0 entries required>=1", tag, i);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_output($sformatf("%s[%0d]", tag, i),
                             {beep_active, env_level, audio_out}, {e.beep, e.level, e.audio});
            end
        end
    endtask

    task automatic restart_model();
        sb.delete();
        edge_k     = 0;
        prev_phase = 1'b0;
        prev_level = 4'd0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_output("reset_hold", {beep_active, env_level, audio_out}, 6'd0);
        rst_n = 1'b1;
        restart_model();

        push_idle(20);
        run_cycles("idle_after_reset", 20);

        apply_stimulus(8'd10, 1'b0);
        push_attack(RAMP + 12);
        run_cycles("attack_a", RAMP / 2 + 4);
        apply_stimulus(8'd30, 1'b0);
        run_cycles("reload", RAMP + 12 - (RAMP / 2 + 4));

        // Reset lands between clock edges, so the check proves it is asynchronous.
        #2 rst_n = 1'b0;
        #1 check_output("async_reset", {beep_active, env_level, audio_out}, 6'd0);
        apply_stimulus(8'd0, 1'b0);
        @(negedge clk);
        check_output("reset_low", {beep_active, env_level, audio_out}, 6'd0);
        rst_n = 1'b1;
        restart_model();
        push_idle(20);
        run_cycles("idle_after_midbeep_reset", 20);

        apply_stimulus(8'd10, 1'b0);
        push_attack(RAMP + 8);
        run_cycles("attack_b", RAMP + 8);
        apply_stimulus(8'd0, 1'b0);
        push_release(RAMP + 8);
        run_cycles("timer_zero", RAMP + 8);

        apply_stimulus(8'd5, 1'b1);
        push_idle(10);
        run_cycles("muted_idle", 10);
        apply_stimulus(8'd5, 1'b0);
        push_attack(RAMP + 8);
        run_cycles("unmute_attack", RAMP + 8);
        apply_stimulus(8'd5, 1'b1);
        push_release(RAMP + 8);
        run_cycles("mute_release", RAMP + 8);

`ifdef CHIP8_BEEPER_ENVELOPE_EN
        apply_stimulus(8'd10, 1'b0);
        push_attack(RAMP + 4);
        run_cycles("attack_c", RAMP + 4);
        apply_stimulus(8'd10, 1'b1);
        push_release(18);
        run_cycles("release_to_7", 18);
        // Re-attack holds level 7 and continues the tone phase, reaching 15 after 16 cycles.
        apply_stimulus(8'd10, 1'b0);
        for (int m = 1; m <= 24; m++) begin
            if (m < 2) push_step(1'b1, 4'd7, phase_of(edge_k));
            else       push_step(1'b1, (7 + (m - 2) / ESC > 15) ? 4'd15 : 4'(7 + (m - 2) / ESC),
                                 phase_of(edge_k));
        end
        run_cycles("reattack", 24);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
